sort8_stream_driver: RTL
========================

// Module: sort8_stream_driver
// PURPOSE
// Initiator/front-end for the 8-lane bitonic sorter. Collects N bytes from a valid/ready input
// stream and presents them in parallel to the sorter. Runs the en/done handshake, then
// serialises the sorted lanes back out as a valid/ready stream with a last flag.
// Also latches the sorter's cycle count for each job.
// PARAMETERS
// W        8   lane/data width in bits
// N        8   lanes per job; fixed at 8 to match the sorter
// TIMEOUT  64  max cycles in REQ waiting for sort_done before the job is aborted
// PORTS
// clk            in   1      rising-edge clock
// reset          in   1      synchronous, active-high reset
// s_valid        in   1      input beat valid
// s_data         in   W      input beat data
// s_ready        out  1      block accepts a beat this cycle
// m_valid        out  1      output beat valid
// m_data         out  W      output beat data (sorted, ascending)
// m_last         out  1      marks beat N-1 of a job
// m_ready        in   1      downstream accepts output beat
// sort_en        out  1      sorter enable (level)
// sort_in_flat   out  N*W    lane i = bits [i*W +: W]; drives sorter in0..in7
// sort_done      in   1      sorter done (level; held while sort_en high)
// sort_out_flat  in   N*W    lane i = bits [i*W +: W]; from sorter out0..out7
// sort_value     in   8      sorter cycle count, valid while sort_done=1
// cycles         out  8      sort_value latched at the last successful job
// busy           out  1      1 in any state other than FILL
// timeout_err    out  1      sticky; set on REQ timeout, cleared only by reset
// BEHAVIOUR
// - Reset (at clk edge with reset=1): state=FILL, idx=0, timeout counter=0.
//   Outputs after reset: s_ready=1; every other output 0, including sort_in_flat, m_data and cycles.
// - FILL:
//   - s_ready=1. A beat transfers when s_valid & s_ready; it is written to lane idx and idx increments.
//   - On the Nth beat: idx<=0, state<=REQ, and sort_en=1 from the next cycle.
// - REQ:
//   - s_ready=0 and sort_en=1. sort_in_flat is held stable for the whole state.
//   - Timeout counter increments every cycle.
//   - On sort_done=1: latch sort_out_flat into the result regs and sort_value into cycles,
//     then go to DRAIN. sort_en goes 0 in the same registered update.
//   - If the counter reaches TIMEOUT-1 with no sort_done: set timeout_err, sort_en<=0,
//     state<=RELEASE. No output beats are produced and cycles is unchanged.
//   - If sort_done and the timeout hit occur in the same cycle, sort_done wins.
// - DRAIN:
//   - m_valid=1 and m_data=result[idx]; m_last=(idx==N-1).
//   - Registered outputs. m_valid, m_data and m_last stay stable until m_ready.
//   - On m_valid & m_ready: idx increments. After the last beat, m_valid<=0 and state<=RELEASE.
//   - m_ready=0 holds indefinitely; there is no timeout in DRAIN.
// - RELEASE:
//   - sort_en=0. Wait for sort_done==0 (the sorter has returned to idle).
//   - Then idx<=0, timeout counter<=0, state<=FILL. Minimum 1 cycle in this state.
// - Beats are never dropped or duplicated in either direction. s_ready and m_valid are never
//   high in the same cycle.
// - Reset mid-job aborts immediately: any partial input job or undrained result is discarded.
// - Sorter latency (en high to done high) is about 8 cycles; correctness must not depend on it.
// TESTING
// 1) Stream 6,3,1,8,9,10,2,4 with m_ready=1 -> m_data 1,2,3,4,6,8,9,10; m_last only on 10;
//    cycles = sorter's count.
// 2) Stream 8,7,6,5,4,3,2,1 with s_valid gaps of 2 cycles -> m_data 1..8; s_ready low from
//    REQ until the next FILL.
// 3) m_ready pattern 1,0,0,1,0,1... during DRAIN -> exactly 8 beats; m_data stable while stalled;
//    no duplicates or drops.
// 4) Sorter stub never asserts done, TIMEOUT=16 -> sort_en high for exactly 16 cycles, then
//    timeout_err=1 and no m_valid. The next job still completes with timeout_err still 1.
// 5) Stub holds sort_done=1 for 5 cycles after en drops -> stays in RELEASE with s_ready=0,
//    and enters FILL the cycle after done falls.
// 6) reset=1 after 3 DRAIN beats -> next cycle m_valid=0, s_ready=1, cycles=0; a fresh job
//    then sorts 5,5,0,255,1,1,7,0 -> 0,0,1,1,5,5,7,255.

Source files
------------

// File: rtl/sort8_stream_driver.sv
// Front-end for the 8-lane bitonic sorter. It gathers N input beats, runs the sorter's
// en/done handshake, and replays the sorted lanes as a valid/ready stream with a last flag.
module sort8_stream_driver #(
  parameter int W       = 8,
  parameter int N       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid,
  input  logic [W-1:0]   s_data,
  output logic           s_ready,
  output logic           m_valid,
  output logic [W-1:0]   m_data,
  output logic           m_last,
  input  logic           m_ready,
  output logic           sort_en,
  output logic [N*W-1:0] sort_in_flat,
  input  logic           sort_done,
  input  logic [N*W-1:0] sort_out_flat,
  input  logic [7:0]     sort_value,
  output logic [7:0]     cycles,
  output logic           busy,
  output logic           timeout_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    REQ     = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         w_idx_inc;
  logic [TW-1:0]         r_tcnt;
  logic [N-1:0][W-1:0]   r_lanes;
  logic [N-1:0][W-1:0]   r_result;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic [W-1:0]          r_m_data;
  logic [7:0]            r_cycles;
  logic                  r_terr;
  logic                  w_s_fire;
  logic                  w_m_fire;
  logic                  w_idx_last;
  logic                  w_tmo;

  assign w_s_fire   = (r_state == FILL) && s_valid;
  assign w_m_fire   = r_m_valid && m_ready;
  assign w_idx_last = (r_idx == IW'(N - 1));
  assign w_idx_inc  = r_idx + IW'(1);
  assign w_tmo      = (r_tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_state_nxt;
  end

  // sort_done takes priority over a timeout that lands on the same cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_s_fire && w_idx_last) w_state_nxt = REQ;
      REQ:     if (sort_done)              w_state_nxt = DRAIN;
               else if (w_tmo)             w_state_nxt = RELEASE;
      DRAIN:   if (w_m_fire && w_idx_last) w_state_nxt = RELEASE;
      RELEASE: if (!sort_done)             w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_tcnt    <= '0;
      r_lanes   <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      r_cycles  <= '0;
      r_terr    <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_s_fire) begin
            r_lanes[r_idx] <= s_data;
            r_idx          <= w_idx_last ? '0 : w_idx_inc;
          end
        end
        REQ: begin
          r_tcnt <= r_tcnt + TW'(1);
          if (sort_done) begin
            r_cycles  <= sort_value;
            r_m_valid <= 1'b1;
            r_m_data  <= sort_out_flat[W-1:0];
            r_m_last  <= (N == 1);
            r_idx     <= '0;
          end else if (w_tmo) begin
            r_terr <= 1'b1;
          end
        end
        DRAIN: begin
          // output beat registers only move on a completed handshake
          if (w_m_fire) begin
            if (w_idx_last) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_idx     <= '0;
            end else begin
              r_idx    <= w_idx_inc;
              r_m_data <= r_result[w_idx_inc];
              r_m_last <= (w_idx_inc == IW'(N - 1));
            end
          end
        end
        RELEASE: begin
          if (!sort_done) begin
            r_idx  <= '0;
            r_tcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == REQ && sort_done) r_result <= sort_out_flat;
  end

  assign s_ready      = (r_state == FILL);
  assign sort_en      = (r_state == REQ);
  assign busy         = (r_state != FILL);
  assign sort_in_flat = r_lanes;
  assign m_valid      = r_m_valid;
  assign m_data       = r_m_data;
  assign m_last       = r_m_last;
  assign cycles       = r_cycles;
  assign timeout_err  = r_terr;

endmodule
